// File: rtl/cache_arbiter_if.sv
// Bundle of the I-side, D-side and shared L2 signals around the cache arbiter.
// slave = arbiter view, master = the L1/L2 environment driving it.
interface cache_arbiter_if;
  logic         i_read;
  logic [31:0]  i_address;
  logic         i_resp;
  logic [255:0] i_rdata;
  logic         d_read;
  logic         d_write;
  logic [31:0]  d_address;
  logic [255:0] d_wdata;
  logic         d_resp;
  logic [255:0] d_rdata;
  logic         l2_read;
  logic         l2_write;
  logic [31:0]  l2_address;
  logic [255:0] l2_wdata;
  logic         l2_resp;
  logic [255:0] l2_rdata;

  modport slave (
    input  i_read, i_address, d_read, d_write, d_address, d_wdata, l2_resp, l2_rdata,
    output i_resp, i_rdata, d_resp, d_rdata, l2_read, l2_write, l2_address, l2_wdata
  );

  modport master (
    output i_read, i_address, d_read, d_write, d_address, d_wdata, l2_resp, l2_rdata,
    input  i_resp, i_rdata, d_resp, d_rdata, l2_read, l2_write, l2_address, l2_wdata
  );
endinterface

// File: rtl/cache_arbiter.sv
// Two-way I/D arbiter onto a single L2 port; D has priority with a starvation cap for I.
// Optional ARB_PERF_CNT_EN adds saturating per-side grant counters.
module cache_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic               clk,
  input  logic               rst,
`ifdef ARB_PERF_CNT_EN
  output logic [31:0]        i_grant_cnt,
  output logic [31:0]        d_grant_cnt,
`endif
  cache_arbiter_if.slave     bus
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SERVE_I = 2'd1;
  localparam logic [1:0] SERVE_D = 2'd2;
  localparam logic [3:0] LIM     = 4'(STARVE_LIMIT);

  logic [1:0] state_q, state_d;
  logic [3:0] streak_q, streak_d;
  logic       d_req, i_turn, serve_i, serve_d;

  assign d_req  = bus.d_read | bus.d_write;
  assign i_turn = bus.i_read && (streak_q == LIM);

  // The state doubles as the registered grant; it is frozen until l2_resp.
  always_comb begin
    state_d  = state_q;
    streak_d = streak_q;
    case (state_q)
      IDLE: begin
        if (d_req && !i_turn) begin
          state_d = SERVE_D;
          if (bus.i_read) streak_d = streak_q + 4'd1;
        end else if (bus.i_read) begin
          state_d  = SERVE_I;
          streak_d = 4'd0;
        end
      end
      SERVE_I, SERVE_D: if (bus.l2_resp) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      streak_q <= 4'd0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
    end
  end

  assign serve_i = (state_q == SERVE_I);
  assign serve_d = (state_q == SERVE_D);

  // A read+write D request is issued as a writeback only.
  assign bus.l2_read    = serve_i | (serve_d & bus.d_read & ~bus.d_write);
  assign bus.l2_write   = serve_d & bus.d_write;
  assign bus.l2_address = serve_d ? bus.d_address : (serve_i ? bus.i_address : 32'd0);
  assign bus.l2_wdata   = serve_d ? bus.d_wdata : 256'd0;
  assign bus.i_resp     = serve_i & bus.l2_resp;
  assign bus.d_resp     = serve_d & bus.l2_resp;
  assign bus.i_rdata    = bus.l2_rdata;
  assign bus.d_rdata    = bus.l2_rdata;

`ifdef ARB_PERF_CNT_EN
  logic [31:0] i_cnt_q, d_cnt_q;
  logic        i_start, d_start;

  assign i_start = (state_q == IDLE) && (state_d == SERVE_I);
  assign d_start = (state_q == IDLE) && (state_d == SERVE_D);

  always_ff @(posedge clk) begin
    if (rst) begin
      i_cnt_q <= 32'd0;
      d_cnt_q <= 32'd0;
    end else begin
      if (i_start && (i_cnt_q != 32'hFFFF_FFFF)) i_cnt_q <= i_cnt_q + 32'd1;
      if (d_start && (d_cnt_q != 32'hFFFF_FFFF)) d_cnt_q <= d_cnt_q + 32'd1;
    end
  end

  assign i_grant_cnt = i_cnt_q;
  assign d_grant_cnt = d_cnt_q;
`endif

endmodule

// File: tb/tb_cache_arbiter.sv
// Self-checking bench for cache_arbiter: directed scenarios plus randomized traffic
// against a transaction-level grant/starvation model.
module tb_cache_arbiter;
  localparam int LIM = 4;

  logic clk, rst;
  int   n_cmp = 0;
  int   n_err = 0;
  int   m_streak = 0;

  cache_arbiter_if bus ();

`ifdef ARB_PERF_CNT_EN
  logic [31:0] i_cnt, d_cnt;
`endif

  cache_arbiter #(.STARVE_LIMIT(LIM)) dut (
    .clk         (clk),
    .rst         (rst),
`ifdef ARB_PERF_CNT_EN
    .i_grant_cnt (i_cnt),
    .d_grant_cnt (d_cnt),
`endif
    .bus         (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int w = 0; w < 8; w++) v[w*32 +: 32] = $urandom;
    return v;
  endfunction

  // Reference: 1 = I wins, 2 = D wins; D preferred unless I has waited LIM D grants.
  function automatic int model_grant(bit ir, bit dr);
    int w;
    if (ir && dr) w = (m_streak == LIM) ? 1 : 2;
    else if (ir)  w = 1;
    else          w = 2;
    if (w == 1) m_streak = 0;
    else if (ir) m_streak = (m_streak < LIM) ? m_streak + 1 : LIM;
    return w;
  endfunction

  task automatic clear_inputs();
    bus.i_read = 0; bus.i_address = '0;
    bus.d_read = 0; bus.d_write = 0; bus.d_address = '0; bus.d_wdata = '0;
    bus.l2_resp = 0; bus.l2_rdata = '0;
  endtask

  task automatic do_reset();
    rst = 1; clear_inputs();
    repeat (2) @(posedge clk);
    #1 rst = 0;
    m_streak = 0;
  endtask

  // Called in IDLE with requests already driven; runs one grant to completion.
  task automatic serve_one(input int side, input int delay, input logic [255:0] data, input string tag);
    logic         e_rd, e_wr;
    logic [31:0]  e_a;
    logic [255:0] e_wd;
    @(posedge clk); #1;
    if (side == 1) begin
      e_rd = 1; e_wr = 0; e_a = bus.i_address; e_wd = '0;
    end else begin
      e_wr = bus.d_write; e_rd = bus.d_read & ~bus.d_write; e_a = bus.d_address; e_wd = bus.d_wdata;
    end
    for (int k = 0; k <= delay; k++) begin
      n_cmp++;
      if (bus.l2_read !== e_rd || bus.l2_write !== e_wr || bus.l2_address !== e_a || bus.l2_wdata !== e_wd) begin
        n_err++;
        $display("FAIL %s l2_req side=%0d: got rd=%b wr=%b addr=%h wd0=%h, want rd=%b wr=%b addr=%h wd0=%h",
                 tag, side, bus.l2_read, bus.l2_write, bus.l2_address, bus.l2_wdata[31:0], e_rd, e_wr, e_a, e_wd[31:0]);
      end
      n_cmp++;
      if (bus.i_resp !== 1'b0 || bus.d_resp !== 1'b0) begin
        n_err++;
        $display("FAIL %s early_resp: got i_resp=%b d_resp=%b, want 0 0", tag, bus.i_resp, bus.d_resp);
      end
      if (k < delay) begin @(posedge clk); #1; end
    end
    bus.l2_rdata = data; bus.l2_resp = 1;
    #1;
    n_cmp++;
    if ((side == 1 && (bus.i_resp !== 1'b1 || bus.d_resp !== 1'b0 || bus.i_rdata !== data)) ||
        (side == 2 && (bus.d_resp !== 1'b1 || bus.i_resp !== 1'b0 || bus.d_rdata !== data))) begin
      n_err++;
      $display("FAIL %s resp side=%0d: got i_resp=%b d_resp=%b rdata0=%h, want side pulse with rdata0=%h",
               tag, side, bus.i_resp, bus.d_resp, (side == 1) ? bus.i_rdata[31:0] : bus.d_rdata[31:0], data[31:0]);
    end
    @(posedge clk); #1;
    bus.l2_resp = 0;
    #1;
    n_cmp++;
    if (bus.l2_read !== 1'b0 || bus.l2_write !== 1'b0 || bus.i_resp !== 1'b0 || bus.d_resp !== 1'b0) begin
      n_err++;
      $display("FAIL %s idle_after: got rd=%b wr=%b i_resp=%b d_resp=%b, want all 0",
               tag, bus.l2_read, bus.l2_write, bus.i_resp, bus.d_resp);
    end
  endtask

  task automatic test_reset();
    rst = 1; clear_inputs();
    bus.i_read = 1; bus.d_read = 1; bus.l2_resp = 1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (bus.l2_read !== 1'b0 || bus.l2_write !== 1'b0 || bus.i_resp !== 1'b0 || bus.d_resp !== 1'b0) begin
      n_err++;
      $display("FAIL reset_outputs: got rd=%b wr=%b i_resp=%b d_resp=%b, want all 0",
               bus.l2_read, bus.l2_write, bus.i_resp, bus.d_resp);
    end
    do_reset();
  endtask

  task automatic test_i_read();
    int s;
    bus.i_read = 1; bus.i_address = 32'h0000_1000;
    s = model_grant(1, 0);
    serve_one(s, 2, {8{32'hAAAA_AAAA}}, "i_read");
    bus.i_read = 0;
  endtask

  task automatic test_d_write();
    int s;
    bus.d_write = 1; bus.d_address = 32'h8000_0040; bus.d_wdata = {8{32'h5555_5555}};
    s = model_grant(0, 1);
    serve_one(s, 1, rand256(), "d_write");
    bus.d_read = 1;  // read+write together must still be a writeback
    s = model_grant(0, 1);
    serve_one(s, 0, rand256(), "d_rw");
    bus.d_write = 0; bus.d_read = 0;
  endtask

  task automatic test_simultaneous();
    int s;
    do_reset();
    bus.i_read = 1; bus.i_address = 32'h0000_2000;
    bus.d_read = 1; bus.d_address = 32'h0000_3000;
    s = model_grant(1, 1);
    serve_one(s, 1, rand256(), "simul_first");
    bus.d_read = 0;
    s = model_grant(1, 0);
    serve_one(s, 1, rand256(), "simul_second");
    bus.i_read = 0;
  endtask

  task automatic test_starve();
    int s;
    do_reset();
    bus.i_read = 1; bus.i_address = 32'h0000_4000;
    bus.d_read = 1; bus.d_address = 32'h0000_5000;
    for (int k = 0; k < LIM + 1; k++) begin
      s = model_grant(1, 1);
      serve_one(s, $urandom_range(0, 2), rand256(), "starve");
      if (s == 1) bus.i_read = 0;
      else bus.d_address = bus.d_address + 32'h40;
    end
    n_cmp++;
    if (dut.streak_q !== 4'(m_streak) || m_streak != 0) begin
      n_err++;
      $display("FAIL starve_streak: got %0d, want 0", dut.streak_q);
    end
    s = model_grant(0, 1);
    serve_one(s, 0, rand256(), "starve_tail");
    bus.d_read = 0;
  endtask

  task automatic test_reset_mid();
    bus.d_read = 1; bus.d_address = 32'h0000_6000;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (bus.l2_read !== 1'b1 || bus.l2_address !== 32'h0000_6000) begin
      n_err++;
      $display("FAIL rstmid_pre: got rd=%b addr=%h, want 1 00006000", bus.l2_read, bus.l2_address);
    end
    rst = 1;
    @(posedge clk); #1;
    rst = 0; bus.d_read = 0; m_streak = 0;
    n_cmp++;
    if (bus.l2_read !== 1'b0 || bus.l2_write !== 1'b0 || bus.d_resp !== 1'b0) begin
      n_err++;
      $display("FAIL rstmid_abort: got rd=%b wr=%b d_resp=%b, want 0 0 0", bus.l2_read, bus.l2_write, bus.d_resp);
    end
    bus.l2_resp = 1; bus.l2_rdata = rand256();
    for (int k = 0; k < 2; k++) begin
      #1;
      n_cmp++;
      if (bus.d_resp !== 1'b0 || bus.i_resp !== 1'b0 || bus.l2_read !== 1'b0) begin
        n_err++;
        $display("FAIL rstmid_late_resp: got d_resp=%b i_resp=%b rd=%b, want 0 0 0", bus.d_resp, bus.i_resp, bus.l2_read);
      end
      @(posedge clk);
    end
    #1 bus.l2_resp = 0;
  endtask

  task automatic test_random();
    bit ir, dr;
    int s, r;
    for (int t = 0; t < 40; t++) begin
      r  = $urandom_range(0, 2);
      ir = (r != 1);
      dr = (r != 0);
      bus.i_read = ir; bus.i_address = $urandom;
      bus.d_address = $urandom; bus.d_wdata = rand256();
      r = $urandom_range(0, 2);
      bus.d_read = dr && (r != 1);
      bus.d_write = dr && (r != 0);
      while (ir || dr) begin
        s = model_grant(ir, dr);
        serve_one(s, $urandom_range(0, 3), rand256(), "random");
        if (s == 1) begin ir = 0; bus.i_read = 0; end
        else begin dr = 0; bus.d_read = 0; bus.d_write = 0; end
      end
    end
  endtask

`ifdef ARB_PERF_CNT_EN
  task automatic test_perf();
    int s;
    do_reset();
    n_cmp++;
    if (i_cnt !== 32'd0 || d_cnt !== 32'd0) begin
      n_err++;
      $display("FAIL perf_reset: got i=%0d d=%0d, want 0 0", i_cnt, d_cnt);
    end
    for (int k = 0; k < 5; k++) begin
      if (k < 3) bus.i_read = 1; else bus.d_read = 1;
      s = model_grant(k < 3, k >= 3);
      serve_one(s, 0, rand256(), "perf");
      bus.i_read = 0; bus.d_read = 0;
    end
    n_cmp++;
    if (i_cnt !== 32'd3 || d_cnt !== 32'd2) begin
      n_err++;
      $display("FAIL perf_counts: got i=%0d d=%0d, want 3 2", i_cnt, d_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_i_read();
    test_d_write();
    test_simultaneous();
    test_starve();
    test_reset_mid();
    test_random();
`ifdef ARB_PERF_CNT_EN
    test_perf();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/cache_arbiter.md
CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 The module SHALL have parameter STARVE_LIMIT, default 4, the number of consecutive D grants allowed while I is pending (range 1..15).
REQ-002 The module SHALL use one clock and a synchronous, active-high reset.
REQ-003 Port `clk`  in  1: clock; all state updates on the rising edge.
REQ-004 Port `rst`  in  1: synchronous, active-high reset.
REQ-005 Port `i_read`  in  1: I-side line read request, held until `i_resp`.
REQ-006 Port `i_address`  in  32: I-side line address.
REQ-007 Port `i_resp`  out  1: one-cycle I-side completion pulse.
REQ-008 Port `i_rdata`  out  256: I-side read line.
REQ-009 Port `d_read` / `d_write`  in  1 each: D-side line read / writeback request, held until `d_resp`.
REQ-010 Port `d_address`  in  32: D-side line address.
REQ-011 Port `d_wdata`  in  256: D-side writeback line.
REQ-012 Port `d_resp`  out  1: one-cycle D-side completion pulse.
REQ-013 Port `d_rdata`  out  256: D-side read line.
REQ-014 Ports `l2_read` / `l2_write`  out  1 each: shared L2 request.
REQ-015 Port `l2_address`  out  32: shared L2 address.
REQ-016 Port `l2_wdata`  out  256: shared L2 write line.
REQ-017 Port `l2_resp`  in  1: L2 completion.
REQ-018 Port `l2_rdata`  in  256: L2 read line.

Function
REQ-019 The FSM SHALL have states IDLE, SERVE_I and SERVE_D, with a registered state and grant.
REQ-020 In IDLE, all of `l2_read`, `l2_write`, `i_resp` and `d_resp` SHALL be 0.
REQ-021 In IDLE with exactly one side requesting, the next state SHALL serve that side.
REQ-022 In IDLE with both sides requesting, the winner SHALL be D, unless `streak` == STARVE_LIMIT, in which case the winner SHALL be I.
REQ-023 `streak` (4-bit) SHALL increment on a D grant while `i_read`=1, SHALL clear on an I grant, and SHALL saturate at STARVE_LIMIT.
REQ-024 In SERVE_I, `l2_read` SHALL be 1, `l2_write` SHALL be 0, `l2_address` SHALL equal `i_address`, and `l2_wdata` SHALL be 0.
REQ-025 In SERVE_D, `l2_read` SHALL equal `d_read & ~d_write`, `l2_write` SHALL equal `d_write`, `l2_address` SHALL equal `d_address`, and `l2_wdata` SHALL equal `d_wdata`.
REQ-026 D requests with both read and write asserted SHALL be treated as a write.
REQ-027 On `l2_resp`=1 in SERVE_x, `x_resp` SHALL be 1 in that same cycle, `x_rdata` SHALL equal `l2_rdata`, and the next state SHALL be IDLE.
REQ-028 `i_rdata` and `d_rdata` SHALL pass `l2_rdata` through combinationally at all times; only the resp pulse qualifies them.
REQ-029 Latency SHALL be 1 cycle from request in IDLE to the L2 request asserted.
REQ-030 The mandatory IDLE cycle after each response SHALL prevent re-issue of a request the L1 is dropping.
REQ-031 The grant SHALL NOT change during SERVE_x, regardless of the other side.
REQ-032 `l2_resp` while in IDLE SHALL be ignored, with no resp pulse.
REQ-033 Requester deassertion before resp is illegal; the arbiter SHALL hold the grant until `l2_resp`.
REQ-034 The non-granted side's resp SHALL remain 0 throughout a transaction.

Reset
REQ-035 When `rst` is sampled 1, the next state SHALL be IDLE, `streak` SHALL be 0, and the performance counters SHALL be 0, including mid-transaction.
REQ-036 After reset, `l2_read`, `l2_write`, `i_resp` and `d_resp` SHALL be 0 from the cycle following the reset edge.
REQ-037 An aborted L2 transaction SHALL NOT produce a resp pulse.

Configuration
REQ-038 When macro ARB_PERF_CNT_EN is defined, the module SHALL add output `i_grant_cnt`  out  32 and output `d_grant_cnt`  out  32.
REQ-039 With ARB_PERF_CNT_EN defined, each counter SHALL increment on each IDLE->SERVE_x transition, SHALL saturate at 0xFFFFFFFF, and SHALL clear on `rst`.
REQ-040 Without ARB_PERF_CNT_EN, the ports and counters SHALL be absent and the remaining behaviour SHALL be identical.

Verification
REQ-041 The bench SHALL cover: `i_read`=1, `i_address`=0x0000_1000, L2 responds 3 cycles later with 0xAA..AA -> `l2_read` from cycle +1; `i_resp` for 1 cycle with `i_rdata`=0xAA..AA; back to IDLE.
REQ-042 The bench SHALL cover: `d_write`=1, `d_address`=0x8000_0040, `d_wdata`=0x55..55 -> `l2_write`=1, `l2_wdata`=0x55..55, `l2_read`=0; `d_resp` pulse on `l2_resp`.
REQ-043 The bench SHALL cover: `i_read` and `d_read` rising in the same cycle, STARVE_LIMIT=4 -> D served first, then I.
REQ-044 The bench SHALL cover: I held continuously, D re-requesting after every resp, STARVE_LIMIT=4 -> 4 D grants, then 1 I grant, with `streak` cleared to 0.
REQ-045 The bench SHALL cover: `rst` asserted 2 cycles into SERVE_D -> L2 signals 0 from the next cycle, no `d_resp`, and a late `l2_resp` ignored.
REQ-046 The bench SHALL cover, with ARB_PERF_CNT_EN: 3 I and 2 D transactions -> `i_grant_cnt`=3, `d_grant_cnt`=2.
